rf_wb_ctrl: RTL and testbench



---
 rtl/rf_wb_ctrl_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 82 ++++++++
 rtl/rf_wb_ctrl.sv | 103 ++++++++++
 tb/tb_rf_wb_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
package rf_wb_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        NORM  = 1'b0,
        DRAIN = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard, outstanding long-op counter, hazard stall and sticky
// protocol-error flag for the register-file write-back path.
module rf_scoreboard
    import rf_wb_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_wen,
    input  logic                  issue_long,
    input  logic                  drain,
    input  logic                  b_acc,
    input  logic [REG_ADDR_W-1:0] b_waddr,
    output logic                  issue_stall,
    output logic                  sb_err
);

    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [PEND_W-1:0]   pend;
    logic [PEND_W-1:0]   pend_nxt;
    logic                pend_full;
    logic                issue_acc;
    logic                pend_inc;
    logic                err_evt;

    assign pend_full = (pend == PEND_W'(MAX_PEND));

    // Hazard checks use the registered busy vector only, so a B write-back
    // unblocks dependants one cycle later, once the regfile holds the value.
    assign issue_stall = rst
                       | busy[issue_rs1]
                       | busy[issue_rs2]
                       | (issue_rd_wen & busy[issue_rd])
                       | (issue_long & pend_full)
                       | drain;

    assign issue_acc = issue_valid & ~issue_stall;
    assign pend_inc  = issue_acc & issue_long;

    assign err_evt = b_acc & (((b_waddr != '0) & ~busy[b_waddr]) | (pend == '0));

    always_comb begin
        busy_nxt = busy;
        if (b_acc) begin
            busy_nxt[b_waddr] = 1'b0;
        end
        if (pend_inc & issue_rd_wen) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        pend_nxt = pend;
        if (pend_inc & ~b_acc) begin
            pend_nxt = pend + PEND_W'(1);
        end else if (b_acc & ~pend_inc & (pend != '0)) begin
            pend_nxt = pend - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            pend   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            pend   <= pend_nxt;
            sb_err <= sb_err | err_evt;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: A/B write-port arbitration, port-B
// starvation drain FSM and the issue-stage scoreboard.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PEND     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rs1_5,
    input  logic [REG_ADDR_W-1:0] i_issue_rs2_5,
    input  logic [REG_ADDR_W-1:0] i_issue_rd_5,
    input  logic                  i_issue_rd_wen,
    input  logic                  i_issue_long,
    output logic                  o_issue_stall,
    input  logic                  i_a_valid,
    input  logic [REG_ADDR_W-1:0] i_a_waddr_5,
    input  logic [XLEN-1:0]       i_a_wdata_32,
    input  logic                  i_b_valid,
    input  logic [REG_ADDR_W-1:0] i_b_waddr_5,
    input  logic [XLEN-1:0]       i_b_wdata_32,
    output logic                  o_b_ready,
    output logic                  o_rf_wen,
    output logic [REG_ADDR_W-1:0] o_rf_waddr_5,
    output logic [XLEN-1:0]       o_rf_wdata_32,
    output logic                  o_sb_err
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_cnt_nxt;
    logic              b_acc;

    assign o_b_ready     = ~rst & ~i_a_valid;
    assign o_rf_wen      = ~rst & (i_a_valid | i_b_valid);
    assign o_rf_waddr_5  = i_a_valid ? i_a_waddr_5  : i_b_waddr_5;
    assign o_rf_wdata_32 = i_a_valid ? i_a_wdata_32 : i_b_wdata_32;
    assign b_acc         = i_b_valid & o_b_ready;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            NORM: begin
                if (b_acc | ~i_b_valid) begin
                    starve_cnt_nxt = '0;
                end else if (i_a_valid) begin
                    // Blocked for the STARVE_LIMIT-th consecutive cycle.
                    if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
                        state_nxt      = DRAIN;
                        starve_cnt_nxt = '0;
                    end else begin
                        starve_cnt_nxt = starve_cnt + SC_W'(1);
                    end
                end
            end
            DRAIN: begin
                starve_cnt_nxt = '0;
                if (b_acc | ~i_b_valid) begin
                    state_nxt = NORM;
                end
            end
            default: begin
                state_nxt      = NORM;
                starve_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORM;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    rf_scoreboard #(
        .MAX_PEND(MAX_PEND)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (i_issue_valid),
        .issue_rs1    (i_issue_rs1_5),
        .issue_rs2    (i_issue_rs2_5),
        .issue_rd     (i_issue_rd_5),
        .issue_rd_wen (i_issue_rd_wen),
        .issue_long   (i_issue_long),
        .drain        (state == DRAIN),
        .b_acc        (b_acc),
        .b_waddr      (i_b_waddr_5),
        .issue_stall  (o_issue_stall),
        .sb_err       (o_sb_err)
    );

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios plus randomized
// traffic checked against a register-level behavioural model.
module tb_rf_wb_ctrl;

    localparam int MAX_PEND     = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wen, is_long;
    logic        stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        b_ready, rf_wen, sb_err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    bit mbusy [32];
    int mpend;
    bit merr;
    int mstreak;
    bit mdrain;

    rf_wb_ctrl #(
        .MAX_PEND(MAX_PEND),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_issue_valid(issue_valid), .i_issue_rs1_5(rs1), .i_issue_rs2_5(rs2),
        .i_issue_rd_5(rd), .i_issue_rd_wen(rd_wen), .i_issue_long(is_long),
        .o_issue_stall(stall),
        .i_a_valid(a_valid), .i_a_waddr_5(a_addr), .i_a_wdata_32(a_data),
        .i_b_valid(b_valid), .i_b_waddr_5(b_addr), .i_b_wdata_32(b_data),
        .o_b_ready(b_ready),
        .o_rf_wen(rf_wen), .o_rf_waddr_5(rf_addr), .o_rf_wdata_32(rf_data),
        .o_sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_stall();
        return rst || mdrain || mbusy[rs1] || mbusy[rs2] ||
               (rd_wen && mbusy[rd]) || (is_long && mpend == MAX_PEND);
    endfunction

    task automatic model_step();
        bit st, iacc, bacc;
        st   = m_stall();
        iacc = issue_valid && !st;
        bacc = b_valid && !a_valid && !rst;
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 0;
            mpend = 0; merr = 0; mstreak = 0; mdrain = 0;
        end else begin
            if (bacc) begin
                if ((b_addr != 0 && !mbusy[b_addr]) || mpend == 0) merr = 1;
                mbusy[b_addr] = 0;
            end
            if (iacc && is_long && rd_wen && rd != 0) mbusy[rd] = 1;
            mpend = mpend + ((iacc && is_long) ? 1 : 0) - (bacc ? 1 : 0);
            if (mpend < 0) mpend = 0;
            if (mdrain) begin
                if (bacc || !b_valid) begin
                    mdrain = 0; mstreak = 0;
                end
            end else if (b_valid && a_valid) begin
                mstreak++;
                if (mstreak == STARVE_LIMIT) begin
                    mdrain = 1; mstreak = 0;
                end
            end else begin
                mstreak = 0;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_wen = 0; is_long = 0;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; a_valid = 1; b_valid = 1; issue_valid = 1;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL reset_stall got=%b exp=1", stall); else passes++;
        checks++; if (rf_wen !== 1'b0) $display("FAIL reset_wen got=%b exp=0", rf_wen); else passes++;
        checks++; if (b_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", b_ready); else passes++;
        cyc();
        cyc();
        idle(); rst = 0;
        issue_valid = 1; rs1 = 3; rs2 = 4; rd = 5; rd_wen = 1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL post_reset_stall got=%b exp=0", stall); else passes++;
        checks++; if (rf_wen !== 1'b0) $display("FAIL post_reset_wen got=%b exp=0", rf_wen); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL post_reset_err got=%b exp=0", sb_err); else passes++;
        cyc();
        idle();
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1; rd = 5; rd_wen = 1; is_long = 1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL raw_long_issue got=%b exp=0", stall); else passes++;
        cyc();
        is_long = 0; rs1 = 5; rd = 10;
        b_valid = 1; b_addr = 5; b_data = 32'hDEADBEEF;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL raw_stall got=%b exp=1", stall); else passes++;
        checks++; if (rf_wen !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF)
            $display("FAIL raw_bwrite got=%b/%0d/%h exp=1/5/deadbeef", rf_wen, rf_addr, rf_data);
        else passes++;
        checks++; if (b_ready !== 1'b1) $display("FAIL raw_ready got=%b exp=1", b_ready); else passes++;
        cyc();
        b_valid = 0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL raw_release got=%b exp=0", stall); else passes++;
        cyc();
        idle();
    endtask

    task automatic test_contention();
        do_reset();
        a_valid = 1; a_addr = 7; a_data = 32'h11;
        b_valid = 1; b_addr = 9; b_data = 32'h22;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h11)
            $display("FAIL cont_a got=%b/%0d/%h exp=1/7/11", rf_wen, rf_addr, rf_data);
        else passes++;
        checks++; if (b_ready !== 1'b0) $display("FAIL cont_ready_a got=%b exp=0", b_ready); else passes++;
        cyc();
        a_valid = 0;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'h22)
            $display("FAIL cont_b got=%b/%0d/%h exp=1/9/22", rf_wen, rf_addr, rf_data);
        else passes++;
        checks++; if (b_ready !== 1'b1) $display("FAIL cont_ready_b got=%b exp=1", b_ready); else passes++;
        cyc();
        idle();
    endtask

    task automatic test_starvation();
        do_reset();
        a_valid = 1; a_addr = 3; a_data = 32'h33;
        b_valid = 1; b_addr = 4; b_data = 32'h44;
        issue_valid = 1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++;
            if (stall !== (k >= STARVE_LIMIT + 1))
                $display("FAIL starve_cycle%0d got=%b exp=%b", k, stall, k >= STARVE_LIMIT + 1);
            else passes++;
            cyc();
        end
        a_valid = 0;
        #1;
        checks++; if (b_ready !== 1'b1 || rf_addr !== 5'd4) $display("FAIL starve_drain_acc got=%b/%0d exp=1/4", b_ready, rf_addr); else passes++;
        checks++; if (stall !== 1'b1) $display("FAIL starve_drain_hold got=%b exp=1", stall); else passes++;
        cyc();
        b_valid = 0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL starve_release got=%b exp=0", stall); else passes++;
        cyc();
        idle();
    endtask

    task automatic test_pend();
        do_reset();
        for (int r = 1; r <= MAX_PEND; r++) begin
            issue_valid = 1; is_long = 1; rd_wen = 1; rd = 5'(r);
            #1;
            checks++; if (stall !== 1'b0) $display("FAIL pend_issue%0d got=%b exp=0", r, stall); else passes++;
            cyc();
        end
        rd = 6;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL pend_full got=%b exp=1", stall); else passes++;
        is_long = 0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL pend_short_ok got=%b exp=0", stall); else passes++;
        cyc();
        idle();
        b_valid = 1; b_addr = 1;
        cyc();
        issue_valid = 1; is_long = 1; rd_wen = 1; rd = 8;
        b_addr = 2;
        #1;
        checks++; if (stall !== 1'b0 || b_ready !== 1'b1) $display("FAIL pend_both got=%b/%b exp=0/1", stall, b_ready); else passes++;
        cyc();
        b_valid = 0; rd = 1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL pend_refill got=%b exp=0", stall); else passes++;
        cyc();
        rd = 9;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL pend_full_again got=%b exp=1", stall); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL pend_no_err got=%b exp=0", sb_err); else passes++;
        idle();
        cyc();
    endtask

    task automatic test_x0_err();
        do_reset();
        issue_valid = 1; is_long = 1; rd_wen = 1; rd = 0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL x0_long got=%b exp=0", stall); else passes++;
        cyc();
        is_long = 0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL x0_not_busy got=%b exp=0", stall); else passes++;
        cyc();
        idle();
        b_valid = 1; b_addr = 8; b_data = 32'h88;
        #1;
        checks++; if (sb_err !== 1'b0) $display("FAIL err_before got=%b exp=0", sb_err); else passes++;
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (sb_err !== 1'b1) $display("FAIL err_sticky%0d got=%b exp=1", k, sb_err); else passes++;
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        #1;
        checks++; if (sb_err !== 1'b0) $display("FAIL err_cleared got=%b exp=0", sb_err); else passes++;
    endtask

    task automatic test_random();
        int a_pct;
        int pick;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            a_pct = (c >= 300 && c < 450) ? 95 : 35;
            rst         = ($urandom_range(0, 149) == 0);
            issue_valid = ($urandom_range(0, 99) < 70);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            rd_wen  = ($urandom_range(0, 99) < 80);
            is_long = ($urandom_range(0, 99) < 40);
            a_valid = ($urandom_range(0, 99) < a_pct);
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = $urandom;
            b_data  = $urandom;
            pick = -1;
            for (int s = 0; s < 8; s++) begin
                int r;
                r = (s + c) % 8;
                if (pick < 0 && mbusy[r]) pick = r;
            end
            if ($urandom_range(0, 99) < 2) begin
                b_valid = 1; b_addr = 5'($urandom_range(0, 31));
            end else begin
                b_valid = (mpend > 0) && ($urandom_range(0, 1) == 1);
                b_addr  = (pick < 0) ? 5'd0 : 5'(pick);
            end
            #1;
            checks++; if (stall !== m_stall()) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, m_stall()); else passes++;
            checks++; if (b_ready !== (!rst && !a_valid)) $display("FAIL rnd_ready c=%0d got=%b", c, b_ready); else passes++;
            checks++; if (rf_wen !== (!rst && (a_valid || b_valid))) $display("FAIL rnd_wen c=%0d got=%b", c, rf_wen); else passes++;
            if (!rst && (a_valid || b_valid)) begin
                checks++;
                if (rf_addr !== (a_valid ? a_addr : b_addr) || rf_data !== (a_valid ? a_data : b_data))
                    $display("FAIL rnd_mux c=%0d got=%0d/%h exp=%0d/%h", c, rf_addr, rf_data,
                             a_valid ? a_addr : b_addr, a_valid ? a_data : b_data);
                else passes++;
            end
            checks++; if (sb_err !== merr) $display("FAIL rnd_err c=%0d got=%b exp=%b", c, sb_err, merr); else passes++;
            cyc();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        mpend = 0; merr = 0; mstreak = 0; mdrain = 0;
        foreach (mbusy[i]) mbusy[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_contention();
        test_starvation();
        test_pend();
        test_x0_err();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
